instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 5: program counter and instruction-memory address width.
REQ-002 The block SHALL have parameter INSTR_WIDTH, default 32: instruction word width.
REQ-003 The block SHALL have parameter RESET_PC, default 0: program counter value after reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port stall, input, 1 bit: downstream cannot accept; hold the PC and the IF/ID register.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: branch/jump taken this cycle.
REQ-008 The block SHALL have port redirect_target, input, ADDR_WIDTH bits: new PC on redirect.
REQ-009 The block SHALL have port imem_address, output, ADDR_WIDTH bits: address to the combinational instruction memory; equals the PC.
REQ-010 The block SHALL have port imem_instruction, input, INSTR_WIDTH bits: word returned by the instruction memory in the same cycle.
REQ-011 The block SHALL have port if_id_instruction, output, INSTR_WIDTH bits: registered fetched instruction.
REQ-012 The block SHALL have port if_id_pc, output, ADDR_WIDTH bits: registered address of if_id_instruction.
REQ-013 The block SHALL have port if_id_valid, output, 1 bit: the IF/ID register holds a real instruction.
REQ-014 The block SHALL have port halted, output, 1 bit: FSM is in HALT.
REQ-015 The block SHALL have port fetch_count, output, 16 bits: number of valid instructions latched into IF/ID.

Function
REQ-016 The block SHALL drive imem_address combinationally from the PC register; memory read latency is zero cycles and the IF/ID latch adds one cycle.
REQ-017 The block SHALL implement a two-state FSM, RUN and HALT, entering RUN on reset.
REQ-018 Each cycle, the block SHALL apply events in priority order: reset > redirect_valid > stall > halt detection > normal fetch.
REQ-019 On a normal fetch in RUN (no stall, no redirect, imem_instruction non-zero), the block SHALL latch if_id_instruction <= imem_instruction, if_id_pc <= PC and if_id_valid <= 1, set PC <= PC+1 modulo 2^ADDR_WIDTH, and increment fetch_count.
REQ-020 PC increment SHALL wrap from 2^ADDR_WIDTH-1 to 0 with no error indication.
REQ-021 When stall=1 and redirect_valid=0, the block SHALL hold PC, if_id_instruction, if_id_pc, if_id_valid, fetch_count and FSM state.
REQ-022 When redirect_valid=1, regardless of stall or state, the block SHALL set PC <= redirect_target, clear if_id_valid to 0 (flush), leave fetch_count unchanged, and set state <= RUN.
REQ-023 When in RUN with no stall or redirect and imem_instruction equals all-zero, the block SHALL treat the word as end-of-program: if_id_valid <= 0, PC held, state <= HALT, fetch_count unchanged.
REQ-024 In HALT without redirect, the block SHALL hold PC, force if_id_valid to 0, and ignore stall and imem_instruction.
REQ-025 The halted output SHALL be 1 exactly while state is HALT.
REQ-026 fetch_count SHALL saturate at 16'hFFFF and not wrap.
REQ-027 if_id_instruction and if_id_pc SHALL retain their last values when if_id_valid is cleared; consumers SHALL qualify them with if_id_valid.

Reset
REQ-028 When reset=1 at a rising clk edge, the block SHALL set PC=RESET_PC, if_id_instruction=0, if_id_pc=0, if_id_valid=0, fetch_count=0 and state=RUN; reset overrides redirect and stall.
REQ-029 Reset asserted mid-operation, including in HALT or during stall, SHALL produce the same state as in REQ-028 on the next edge.
REQ-030 On the first edge after reset deasserts, the block SHALL fetch from RESET_PC.

Verification
REQ-031 Sequential run: memory holds non-zero words at 0-5 and zero elsewhere; release reset -> if_id_pc = 0,1,...,5 on consecutive cycles with if_id_valid=1, then halted=1 with PC=6, if_id_valid=0 and fetch_count=6.
REQ-032 Stall: assert stall for 3 cycles while PC=2 -> PC, if_id_pc=1 and fetch_count=2 are unchanged for 3 cycles; fetch resumes at address 2 after release.
REQ-033 Redirect during stall: stall=1, redirect_valid=1, target=4 -> next cycle PC=4 and if_id_valid=0; the following cycle if_id_pc=4 and if_id_valid=1.
REQ-034 Halt exit: in HALT, redirect_valid=1 with target=0 -> halted=0 and PC=0, and fetch restarts; fetch_count continues from 6.
REQ-035 Wrap: all memory words non-zero, run 33 cycles -> PC goes 31 to 0, if_id_pc sequence 30, 31, 0, and no halt.
REQ-036 Mid-run reset: assert reset at PC=3 with if_id_valid=1 -> next cycle PC=0, if_id_valid=0, fetch_count=0 and halted=0.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: PC register, combinational instruction-memory address,
// IF/ID pipeline register and a RUN/HALT controller that stops on an all-zero word.
module instruction_fetch_unit #(
   parameter int                    ADDR_WIDTH  = 5,
   parameter int                    INSTR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   redirect_valid,
   input  logic [ADDR_WIDTH-1:0]  redirect_target,
   output logic [ADDR_WIDTH-1:0]  imem_address,
   input  logic [INSTR_WIDTH-1:0] imem_instruction,
   output logic [INSTR_WIDTH-1:0] if_id_instruction,
   output logic [ADDR_WIDTH-1:0]  if_id_pc,
   output logic                   if_id_valid,
   output logic                   halted,
   output logic [15:0]            fetch_count
);

   typedef enum logic [0:0] {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_e;

   localparam logic [ADDR_WIDTH-1:0]  PC_ONE      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [INSTR_WIDTH-1:0] INSTR_ZERO  = {INSTR_WIDTH{1'b0}};
   localparam logic [15:0]            COUNT_MAX   = 16'hFFFF;

   state_e                   state_q, state_d;
   logic [ADDR_WIDTH-1:0]    pc_q, pc_d;
   logic [INSTR_WIDTH-1:0]   if_id_instruction_q, if_id_instruction_d;
   logic [ADDR_WIDTH-1:0]    if_id_pc_q, if_id_pc_d;
   logic                     if_id_valid_q, if_id_valid_d;
   logic [15:0]              fetch_count_q, fetch_count_d;

   // Next-state logic; redirect outranks stall, stall outranks halt detection.
   always_comb begin
      state_d             = state_q;
      pc_d                = pc_q;
      if_id_instruction_d = if_id_instruction_q;
      if_id_pc_d          = if_id_pc_q;
      if_id_valid_d       = if_id_valid_q;
      fetch_count_d       = fetch_count_q;

      if (redirect_valid) begin
         pc_d          = redirect_target;
         if_id_valid_d = 1'b0;
         state_d       = ST_RUN;
      end else if (stall) begin
         state_d = state_q;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (imem_instruction == INSTR_ZERO) begin
                  if_id_valid_d = 1'b0;
                  state_d       = ST_HALT;
               end else begin
                  if_id_instruction_d = imem_instruction;
                  if_id_pc_d          = pc_q;
                  if_id_valid_d       = 1'b1;
                  pc_d                = pc_q + PC_ONE;
                  if (fetch_count_q != COUNT_MAX) begin
                     fetch_count_d = fetch_count_q + 16'd1;
                  end else begin
                     fetch_count_d = fetch_count_q;
                  end
               end
            end
            ST_HALT: begin
               if_id_valid_d = 1'b0;
            end
            default: begin
               state_d       = ST_RUN;
               if_id_valid_d = 1'b0;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q             <= ST_RUN;
         pc_q                <= RESET_PC;
         if_id_instruction_q <= INSTR_ZERO;
         if_id_pc_q          <= {ADDR_WIDTH{1'b0}};
         if_id_valid_q       <= 1'b0;
         fetch_count_q       <= 16'd0;
      end else begin
         state_q             <= state_d;
         pc_q                <= pc_d;
         if_id_instruction_q <= if_id_instruction_d;
         if_id_pc_q          <= if_id_pc_d;
         if_id_valid_q       <= if_id_valid_d;
         fetch_count_q       <= fetch_count_d;
      end
   end

   assign imem_address      = pc_q;
   assign if_id_instruction = if_id_instruction_q;
   assign if_id_pc          = if_id_pc_q;
   assign if_id_valid       = if_id_valid_q;
   assign halted            = (state_q == ST_HALT);
   assign fetch_count       = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: vector table, directed corner
// sequences and randomized traffic against an abstract fetch model.
module tb_instruction_fetch_unit;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [4:0]  redirect_target;
   logic [4:0]  imem_address;
   logic [31:0] imem_instruction;
   logic [31:0] if_id_instruction;
   logic [4:0]  if_id_pc;
   logic        if_id_valid;
   logic        halted;
   logic [15:0] fetch_count;

   logic [31:0] mem [32];

   int pass_cnt;
   int total_cnt;

   // abstract model state
   int          m_pc;
   int          m_ipc;
   int          m_count;
   bit          m_valid;
   bit          m_halted;
   logic [31:0] m_instr;

   typedef struct {
      logic        rst;
      logic        stl;
      logic        rdr;
      logic [4:0]  tgt;
      logic [4:0]  pc;
      logic [4:0]  ipc;
      logic        v;
      logic        h;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs [15];

   instruction_fetch_unit dut (
      .clk               (clk),
      .reset             (reset),
      .stall             (stall),
      .redirect_valid    (redirect_valid),
      .redirect_target   (redirect_target),
      .imem_address      (imem_address),
      .imem_instruction  (imem_instruction),
      .if_id_instruction (if_id_instruction),
      .if_id_pc          (if_id_pc),
      .if_id_valid       (if_id_valid),
      .halted            (halted),
      .fetch_count       (fetch_count)
   );

   assign imem_instruction = mem[imem_address];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         pass_cnt++;
      end
   endtask

   // Model of one clock edge, using the inputs and memory as they stand now.
   task automatic model_step();
      if (reset) begin
         m_pc = 0; m_instr = 32'd0; m_ipc = 0; m_valid = 1'b0; m_count = 0; m_halted = 1'b0;
      end else if (redirect_valid) begin
         m_pc = int'(redirect_target); m_valid = 1'b0; m_halted = 1'b0;
      end else if (stall) begin
         m_halted = m_halted;
      end else if (m_halted) begin
         m_valid = 1'b0;
      end else if (mem[m_pc] == 32'd0) begin
         m_valid = 1'b0; m_halted = 1'b1;
      end else begin
         m_instr = mem[m_pc];
         m_ipc   = m_pc;
         m_valid = 1'b1;
         m_pc    = (m_pc + 1) % 32;
         if (m_count < 65535) m_count = m_count + 1;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      check("imem_address", 64'(imem_address), 64'(m_pc));
      check("if_id_valid", 64'(if_id_valid), 64'(m_valid));
      check("if_id_pc", 64'(if_id_pc), 64'(m_ipc));
      check("if_id_instruction", 64'(if_id_instruction), 64'(m_instr));
      check("halted", 64'(halted), 64'(m_halted));
      check("fetch_count", 64'(fetch_count), 64'(m_count));
   endtask

   task automatic drive(input logic r, input logic s, input logic d, input logic [4:0] t);
      reset = r; stall = s; redirect_valid = d; redirect_target = t;
   endtask

   initial begin
      pass_cnt = 0; total_cnt = 0;
      m_pc = 0; m_ipc = 0; m_count = 0; m_valid = 1'b0; m_halted = 1'b0; m_instr = 32'd0;
      drive(1'b1, 1'b0, 1'b0, 5'd0);
      for (int i = 0; i < 32; i++) mem[i] = (i < 6) ? (32'h1000_0000 + 32'(i)) : 32'd0;

      //          rst   stl   rdr   tgt    pc     ipc    v     h     cnt
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 16'd0};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 16'd1};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 5'd1, 1'b1, 1'b0, 16'd2};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd2, 1'b1, 1'b0, 16'd3};
      vecs[4]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd4, 5'd3, 1'b1, 1'b0, 16'd4};
      vecs[5]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd5, 5'd4, 1'b1, 1'b0, 16'd5};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd5, 1'b1, 1'b0, 16'd6};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd5, 1'b0, 1'b1, 16'd6};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 5'd0, 5'd6, 5'd5, 1'b0, 1'b1, 16'd6};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd6, 5'd5, 1'b0, 1'b1, 16'd6};
      vecs[10] = '{1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 1'b0, 1'b0, 16'd6};
      vecs[11] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 16'd7};
      vecs[12] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd2, 5'd1, 1'b1, 1'b0, 16'd8};
      vecs[13] = '{1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd2, 1'b1, 1'b0, 16'd9};
      vecs[14] = '{1'b1, 1'b1, 1'b1, 5'd9, 5'd0, 5'd0, 1'b0, 1'b0, 16'd0};

      for (int i = 0; i < 15; i++) begin
         drive(vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].tgt);
         tick();
         check($sformatf("vec%0d_pc", i), 64'(imem_address), 64'(vecs[i].pc));
         check($sformatf("vec%0d_ipc", i), 64'(if_id_pc), 64'(vecs[i].ipc));
         check($sformatf("vec%0d_valid", i), 64'(if_id_valid), 64'(vecs[i].v));
         check($sformatf("vec%0d_halted", i), 64'(halted), 64'(vecs[i].h));
         check($sformatf("vec%0d_count", i), 64'(fetch_count), 64'(vecs[i].cnt));
      end

      // stall three cycles at PC=2, then resume from address 2
      drive(1'b0, 1'b0, 1'b0, 5'd0);
      tick(); tick();
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 1'b1, 1'b0, 5'd0);
         tick();
         check("stall_pc", 64'(imem_address), 64'd2);
         check("stall_ipc", 64'(if_id_pc), 64'd1);
         check("stall_count", 64'(fetch_count), 64'd2);
      end
      drive(1'b0, 1'b0, 1'b0, 5'd0);
      tick();
      check("resume_ipc", 64'(if_id_pc), 64'd2);
      check("resume_pc", 64'(imem_address), 64'd3);

      // redirect while stalled
      drive(1'b0, 1'b1, 1'b1, 5'd4);
      tick();
      check("redir_pc", 64'(imem_address), 64'd4);
      check("redir_flush", 64'(if_id_valid), 64'd0);
      drive(1'b0, 1'b0, 1'b0, 5'd0);
      tick();
      check("redir_ipc", 64'(if_id_pc), 64'd4);
      check("redir_valid", 64'(if_id_valid), 64'd1);

      // run into halt, then reset while halted and stalled
      tick(); tick(); tick();
      check("halt_reached", 64'(halted), 64'd1);
      drive(1'b1, 1'b1, 1'b0, 5'd0);
      tick();
      check("halt_reset", 64'(halted), 64'd0);
      check("halt_reset_pc", 64'(imem_address), 64'd0);

      // wrap: every word non-zero, 33 fetch cycles
      for (int i = 0; i < 32; i++) mem[i] = 32'hC000_0000 | 32'(i);
      drive(1'b1, 1'b0, 1'b0, 5'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 5'd0);
      for (int c = 1; c <= 33; c++) begin
         tick();
         check("wrap_no_halt", 64'(halted), 64'd0);
         if (c == 31) check("wrap_ipc30", 64'(if_id_pc), 64'd30);
         if (c == 32) begin
            check("wrap_ipc31", 64'(if_id_pc), 64'd31);
            check("wrap_pc0", 64'(imem_address), 64'd0);
         end
         if (c == 33) check("wrap_ipc0", 64'(if_id_pc), 64'd0);
      end

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         if ($urandom_range(0, 2) == 0)
            mem[$urandom_range(0, 31)] = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom | 32'd1);
         drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)));
         tick();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
